// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle for the multi-cycle ALU.
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            kill;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] ina;
    logic [XLEN-1:0] inb;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output kill, in_valid, alu_op, ina, inb, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  kill, in_valid, alu_op, ina, inb, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/M ALU: single-cycle logic/arith/shift ops, iterative
// one-bit-per-cycle shift-add multiply and restoring divide.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    logic [1:0]      state;
    logic [SHW-1:0]  cnt;
    logic [3:0]      op_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    // hi/lo: product halves for multiply, remainder/quotient for divide.
    // m: multiplicand for multiply, divisor magnitude for divide.
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] m;
    logic [XLEN-1:0] res_p1;
    logic            zero_p1;

    logic [XLEN-1:0] nxt_hi;
    logic [XLEN-1:0] nxt_lo;
    logic [XLEN-1:0] fin;
    logic [XLEN-1:0] res_1c;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return cond_neg(x, sgn & x[XLEN-1]);
    endfunction

    // Codes 1010..1111 take the iterative path; 1000/1001 are single-cycle.
    function automatic logic is_multi(input logic [3:0] op);
        return op[3] & (op[2] | op[1]);
    endfunction

    function automatic logic [XLEN-1:0] alu_1c(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic signed [XLEN-1:0] sra;
        logic [XLEN-1:0]        r;
        sa  = a;
        sb  = b;
        sra = sa >>> b[SHW-1:0];
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << b[SHW-1:0];
            4'b0101: r = a >> b[SHW-1:0];
            4'b1001: r = sra;
            4'b0111: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1000: r = {{(XLEN-1){1'b0}}, (sa < sb)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign res_1c        = alu_1c(bus.alu_op, bus.ina, bus.inb);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_p1;
    assign bus.zero      = zero_p1;

    // One iteration of multiply or divide, plus the sign-fixed final value.
    always_comb begin
        logic [XLEN:0] sum;
        logic [XLEN:0] shifted;
        logic [XLEN:0] dsub;
        logic          ge;
        logic          q_neg;
        logic          r_neg;
        nxt_hi  = hi;
        nxt_lo  = lo;
        fin     = '0;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi, lo[XLEN-1]};
        dsub    = shifted - {1'b0, m};
        ge      = (shifted >= {1'b0, m});
        q_neg   = op_r[1] & (a_r[XLEN-1] ^ b_r[XLEN-1]);
        r_neg   = op_r[1] & a_r[XLEN-1];
        if (op_r[2] == 1'b0) begin
            nxt_hi = sum[XLEN:1];
            nxt_lo = {sum[0], lo[XLEN-1:1]};
            fin    = op_r[0] ? nxt_hi : nxt_lo;
        end else begin
            nxt_hi = ge ? dsub[XLEN-1:0] : shifted[XLEN-1:0];
            nxt_lo = {lo[XLEN-2:0], ge};
            if (b_r == '0)
                fin = op_r[0] ? a_r : '1;
            else if (op_r[0])
                fin = cond_neg(nxt_hi, r_neg);
            else
                fin = cond_neg(nxt_lo, q_neg);
        end
    end

    // Control FSM and iteration counter; kill overrides accept and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.kill) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= is_multi(bus.alu_op) ? BUSY : DONE;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered result and zero flag; held through kill and while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1  <= '0;
            zero_p1 <= 1'b0;
        end else if (!bus.kill) begin
            if (state == IDLE && bus.in_valid && !is_multi(bus.alu_op)) begin
                res_p1  <= res_1c;
                zero_p1 <= (res_1c == '0);
            end else if (state == BUSY && cnt == CNT_LAST) begin
                res_p1  <= fin;
                zero_p1 <= (fin == '0);
            end
        end
    end

    // Operand latch at accept and iterative datapath state.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid && !bus.kill) begin
            op_r <= bus.alu_op;
            a_r  <= bus.ina;
            b_r  <= bus.inb;
            if (bus.alu_op[2] == 1'b0) begin
                hi <= '0;
                lo <= bus.inb;
                m  <= bus.ina;
            end else begin
                hi <= '0;
                lo <= magnitude(bus.ina, bus.alu_op[1]);
                m  <= magnitude(bus.inb, bus.alu_op[1]);
            end
        end else if (state == BUSY) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
        end
    end

endmodule
